// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the 4:1 mux scan controller.
// Channel order and the "next enabled channel" search live here so the FSM stays small.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] CH_A = 2'd0;
    localparam logic [1:0] CH_B = 2'd1;
    localparam logic [1:0] CH_C = 2'd2;
    localparam logic [1:0] CH_D = 2'd3;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } ch_sel_t;

    // Next enabled channel strictly above idx; the scan never wraps back to channel 0.
    function automatic ch_sel_t next_en(input logic [1:0] idx, input logic [3:0] mask);
        ch_sel_t r;
        r.found = 1'b0;
        r.idx   = idx;
        for (int i = 3; i >= 0; i--) begin
            if ((i > int'(idx)) && mask[i]) begin
                r.found = 1'b1;
                r.idx   = 2'(i);
            end
        end
        return r;
    endfunction

    function automatic ch_sel_t first_en(input logic [3:0] mask);
        ch_sel_t r;
        r.found = 1'b0;
        r.idx   = CH_A;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) begin
                r.found = 1'b1;
                r.idx   = 2'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux4_dwell_cnt.sv
// Dwell counter: counts cycles a channel has been selected and flags the sampling cycle.
// Clear has priority over enable; term_o is high while the count equals DWELL-1.
module mux4_dwell_cnt #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic term_o
);

    localparam logic [CNT_W-1:0] TERM_VAL = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        // NOTE: default-assign every always_comb output first so no path leaves it unassigned (no latch).
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term_o = (cnt_q == TERM_VAL);

endmodule

// File: rtl/mux4_scan_ctrl.sv
// Scans the enabled channels of a 4:1 mux in ascending order, dwelling DWELL cycles on each,
// and presents the sampled bits as one 4-bit frame on a valid/ready handshake.
module mux4_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cont,
    input  logic [3:0] ch_en,
    input  logic       mux_y,
    output logic       s,
    output logic       s0,
    output logic [3:0] frame,
    output logic       frame_valid,
    input  logic       frame_ready,
    output logic       busy
);

    state_e     state_q, state_d;
    logic [1:0] sel_q,   sel_d;
    logic [3:0] frame_q, frame_d;
    logic [3:0] mask_q,  mask_d;

    logic    dwell_done;
    logic    launch;
    ch_sel_t first_ch;
    ch_sel_t next_ch;

    mux4_dwell_cnt #(
        .DWELL (DWELL),
        .CNT_W (CNT_W)
    ) u_dwell_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  ((state_q != SCAN) || dwell_done),
        .en_i   (state_q == SCAN),
        .term_o (dwell_done)
    );

    // A scan starts from IDLE on start, or back-to-back from DONE on a handshake in continuous mode.
    assign launch   = ((state_q == IDLE) && start) ||
                      ((state_q == DONE) && frame_ready && cont);
    assign first_ch = first_en(ch_en);
    assign next_ch  = next_en(sel_q, mask_q);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        frame_d = frame_q;
        mask_d  = mask_q;
        if (launch) begin
            mask_d  = ch_en;
            frame_d = '0;
            if (first_ch.found) begin
                state_d = SCAN;
                sel_d   = first_ch.idx;
            end else begin
                state_d = DONE;
            end
        end else begin
            case (state_q)
                SCAN: begin
                    if (dwell_done) begin
                        frame_d[sel_q] = mux_y;
                        if (next_ch.found) begin
                            sel_d = next_ch.idx;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (frame_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: mask and frame are ordinary flops, so they take the async reset like the rest; only RAM arrays stay unreset.
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= CH_A;
            frame_q <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            frame_q <= frame_d;
            mask_q  <= mask_d;
        end
    end

    assign s           = sel_q[1];
    assign s0          = sel_q[0];
    assign frame       = frame_q;
    assign frame_valid = (state_q == DONE);
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Scoreboard bench for mux4_scan_ctrl: two instances (DWELL=4 and DWELL=1) driven by a
// cycle-indexed data plan; expected frames and per-cycle status are queued and checked by a monitor.
module tb_mux4_scan_ctrl;

    localparam int DW0 = 4;
    localparam int DW1 = 1;

    typedef struct {
        int         cyc;
        int         u;
        logic [1:0] sel;
        logic       chk_sel;
        logic       busy;
        logic       valid;
    } cyc_exp_t;

    typedef struct {
        int         u;
        int         t_valid;
        logic [3:0] frame;
        logic [1:0] last_sel;
        logic       has_sel;
    } frm_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] start_v, cont_v, ready_v, mux_y_v, s_v, s0_v, valid_v, busy_v;
    logic [1:0][3:0] ch_en_v, data_v, frame_v;

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    cyc_exp_t   cq[$];
    frm_exp_t   fq[$];
    frm_exp_t   cur[2];
    logic [1:0] shown;
    logic [3:0] plan[int];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign mux_y_v[g] = data_v[g][{s_v[g], s0_v[g]}];
        mux4_scan_ctrl #(
            .DWELL ((g == 0) ? DW0 : DW1),
            .CNT_W (8)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .start       (start_v[g]),
            .cont        (cont_v[g]),
            .ch_en       (ch_en_v[g]),
            .mux_y       (mux_y_v[g]),
            .s           (s_v[g]),
            .s0          (s0_v[g]),
            .frame       (frame_v[g]),
            .frame_valid (valid_v[g]),
            .frame_ready (ready_v[g]),
            .busy        (busy_v[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) tick();
    endtask

    // Reference model: enabled channels in ascending order, each held dw cycles,
    // sampled on its last held cycle; valid rises one cycle after the last sample.
    task automatic expect_scan(input int u, input int t0, input logic [3:0] mask,
                               input bit rnd, input logic [3:0] cdata, output frm_exp_t fe);
        int dw = (u == 0) ? DW0 : DW1;
        int t  = t0;
        int n  = 0;
        logic [3:0] d;
        cyc_exp_t ce;
        fe.u        = u;
        fe.frame    = '0;
        fe.last_sel = '0;
        fe.has_sel  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                for (int j = 1; j <= dw; j++) begin
                    t++;
                    d = rnd ? 4'($urandom) : cdata;
                    plan[t*2 + u] = d;
                    ce.cyc = t; ce.u = u; ce.sel = 2'(i); ce.chk_sel = 1'b1;
                    ce.busy = 1'b1; ce.valid = 1'b0;
                    cq.push_back(ce);
                    if (j == dw) fe.frame[i] = d[i];
                end
                fe.last_sel = 2'(i);
                fe.has_sel  = 1'b1;
                n++;
            end
        end
        fe.t_valid = t0 + 1 + n*dw;
        fq.push_back(fe);
    endtask

    task automatic handshake(input int u, input frm_exp_t fe);
        cyc_exp_t ce;
        ready_v[u] = 1'b1;
        cont_v[u]  = 1'b0;
        ce.cyc = cyc + 1; ce.u = u; ce.sel = fe.last_sel; ce.chk_sel = fe.has_sel;
        ce.busy = 1'b0; ce.valid = 1'b0;
        cq.push_back(ce);
        tick();
        ready_v[u] = 1'b0;
    endtask

    task automatic run_scan(input int u, input logic [3:0] mask, input bit rnd,
                            input logic [3:0] cdata, input int hold);
        int t0;
        frm_exp_t fe;
        ch_en_v[u] = mask;
        start_v[u] = 1'b1;
        t0 = cyc;
        expect_scan(u, t0, mask, rnd, cdata, fe);
        tick();
        start_v[u] = 1'b0;
        ch_en_v[u] = 4'($urandom);
        wait_to(fe.t_valid + hold/2);
        if (hold > 0) begin
            start_v[u] = 1'b1;
            tick();
            start_v[u] = 1'b0;
        end
        wait_to(fe.t_valid + hold);
        handshake(u, fe);
    endtask

    // Applies the planned mux data inputs at the start of each cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int u = 0; u < 2; u++) begin
                if (plan.exists(cyc*2 + u)) data_v[u] = plan[cyc*2 + u];
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int u = 0; u < 2; u++) begin
                if (valid_v[u]) begin
                    if (!shown[u]) begin
                        if (fq.size() == 0 || fq[0].u != u) begin
                            check("spurious_valid", 32'(valid_v[u]), 32'(0));
                        end else begin
                            cur[u]   = fq.pop_front();
                            shown[u] = 1'b1;
                            check("frame", 32'(frame_v[u]), 32'(cur[u].frame));
                            check("valid_cycle", 32'(cyc), 32'(cur[u].t_valid));
                        end
                    end else begin
                        check("frame_hold", 32'(frame_v[u]), 32'(cur[u].frame));
                        if (cur[u].has_sel)
                            check("sel_hold", 32'({s_v[u], s0_v[u]}), 32'(cur[u].last_sel));
                    end
                    if (ready_v[u]) shown[u] = 1'b0;
                end
            end
            while (cq.size() > 0 && cq[0].cyc <= cyc) begin
                cyc_exp_t e;
                e = cq.pop_front();
                check("busy", 32'(busy_v[e.u]), 32'(e.busy));
                check("valid_low", 32'(valid_v[e.u]), 32'(e.valid));
                if (e.chk_sel)
                    check("select", 32'({s_v[e.u], s0_v[e.u]}), 32'(e.sel));
            end
        end
    end

    initial begin
        int t0, t1;
        frm_exp_t fe, fe2;
        start_v = '0; cont_v = '0; ready_v = '0; ch_en_v = '0; data_v = '0; shown = '0;

        repeat (3) tick();
        for (int u = 0; u < 2; u++) begin
            check("rst_sel", 32'({s_v[u], s0_v[u]}), 32'(0));
            check("rst_frame", 32'(frame_v[u]), 32'(0));
            check("rst_valid", 32'(valid_v[u]), 32'(0));
            check("rst_busy", 32'(busy_v[u]), 32'(0));
        end
        rst_n = 1'b1;
        repeat (2) tick();

        // All channels, a=1 b=0 c=1 d=1.
        run_scan(0, 4'b1111, 1'b0, 4'b1101, 0);
        tick();
        // Sparse mask; a and c high but disabled.
        run_scan(0, 4'b1010, 1'b0, 4'b0111, 0);
        tick();
        // Empty mask, then backpressure with an ignored start.
        run_scan(0, 4'b0000, 1'b0, 4'b0000, 0);
        tick();
        run_scan(0, 4'b1111, 1'b0, 4'b1101, 10);
        tick();

        // Continuous mode with a mask change before the handshake.
        ch_en_v[0] = 4'b1111;
        start_v[0] = 1'b1;
        t0 = cyc;
        expect_scan(0, t0, 4'b1111, 1'b1, 4'b0000, fe);
        tick();
        start_v[0] = 1'b0;
        wait_to(fe.t_valid - 3);
        ch_en_v[0] = 4'b0001;
        wait_to(fe.t_valid);
        ready_v[0] = 1'b1;
        cont_v[0]  = 1'b1;
        t1 = cyc;
        expect_scan(0, t1, 4'b0001, 1'b1, 4'b0000, fe2);
        tick();
        ready_v[0] = 1'b0;
        cont_v[0]  = 1'b0;
        wait_to(fe2.t_valid);
        handshake(0, fe2);
        tick();

        // Reset during cycle 6 of a full scan.
        ch_en_v[0] = 4'b1111;
        start_v[0] = 1'b1;
        t0 = cyc;
        expect_scan(0, t0, 4'b1111, 1'b0, 4'b1101, fe);
        tick();
        start_v[0] = 1'b0;
        wait_to(t0 + 6);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_sel", 32'({s_v[0], s0_v[0]}), 32'(0));
        check("abort_frame", 32'(frame_v[0]), 32'(0));
        check("abort_valid", 32'(valid_v[0]), 32'(0));
        check("abort_busy", 32'(busy_v[0]), 32'(0));
        cq.delete();
        fq.delete();
        shown = '0;
        tick();
        rst_n = 1'b1;
        tick();
        run_scan(0, 4'b1111, 1'b0, 4'b1101, 0);
        tick();

        // DWELL=1 instance, data changing every cycle.
        run_scan(1, 4'b1111, 1'b1, 4'b0000, 0);
        tick();

        for (int k = 0; k < 10; k++) begin
            run_scan(int'($urandom_range(0, 1)), 4'($urandom), 1'b1, 4'b0000,
                     int'($urandom_range(0, 3)));
            tick();
        end

        repeat (3) tick();
        check("frames_outstanding", 32'(fq.size()), 32'(0));
        check("cycles_outstanding", 32'(cq.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mux4_scan_ctrl.md
Name: mux4_scan_ctrl

Overview:
Upstream controller for the 4:1 mux (data inputs a/b/c/d, select s/s0, output y). It drives the select lines through the enabled channels in ascending order and holds each channel for a programmable dwell time. On the last dwell cycle of each channel it samples the mux output, then presents the four sampled bits as one frame on a valid/ready handshake. It sits between the stimulus/control logic and the mux, and turns a single-bit mux into a scanned 4-bit reader.

Parameters:
DWELL, 4, cycles each channel is held selected before sampling; legal range 1..255.
CNT_W, 8, width of the dwell counter; must satisfy 2**CNT_W > DWELL.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  request a scan; sampled only in IDLE.
cont  input  1  continuous mode; sampled at each frame handshake.
ch_en  input  4  channel enable mask; bit i enables channel i (0=a, 1=b, 2=c, 3=d); latched at scan start.
mux_y  input  1  output y of the 4:1 mux.
s  output  1  select MSB to the mux.
s0  output  1  select LSB to the mux.
frame  output  4  sampled values; bit i = mux_y sampled while channel i was selected.
frame_valid  output  1  frame is complete and stable.
frame_ready  input  1  consumer accepts the frame.
busy  output  1  high in SCAN and DONE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; s=0, s0=0, frame=0, frame_valid=0, busy=0; dwell counter=0; latched mask=0.
- {s,s0} is a registered copy of the current channel index. There is no combinational path from any input to s/s0.
- IDLE:
  - start=1 → latch ch_en, clear frame to 0.
  - If the mask is non-zero → SCAN, with {s,s0} = lowest enabled index and counter=0.
  - If the mask is zero → DONE directly; frame_valid=1 on the next cycle with frame=0.
- SCAN:
  - The counter increments each cycle.
  - When counter==DWELL-1: frame[idx] <= mux_y, counter <= 0, and {s,s0} moves to the next higher enabled index.
  - If no higher enabled index exists → DONE.
  - Disabled channels are never selected; their frame bits stay 0.
- DONE:
  - frame_valid=1; frame and {s,s0} are held stable while frame_ready=0.
  - On frame_valid && frame_ready: frame_valid drops the next cycle.
  - If cont=1 → re-latch ch_en, clear frame, re-enter SCAN (or DONE if the mask is zero).
  - If cont=0 → IDLE.
- start is ignored while busy=1.
- ch_en changes during SCAN/DONE have no effect until the next latch.
- Latency: with N enabled channels, frame_valid rises exactly 1 + N*DWELL cycles after the start cycle. With N=0 it rises 1 cycle after.
- DWELL=1: a channel is sampled on its first selected cycle. The select changes every cycle.
- Wrap-around: the channel index never wraps inside a scan. A scan ends after channel 3 or the highest enabled channel.
- Reset asserted mid-scan or in DONE: immediate abort to reset values. No partial frame is presented.
- busy = (state != IDLE).

Decomposition:
- Shared package mux_scan_pkg:
  - state enum: IDLE=2'd0, SCAN=2'd1, DONE=2'd2.
  - channel index constants: CH_A=0, CH_B=1, CH_C=2, CH_D=3.
  - function next_en(idx, mask): returns the next higher enabled index plus a found flag.
- One natural sub-module, mux4_dwell_cnt: a CNT_W-bit counter with clear and a terminal flag (count==DWELL-1).
- The FSM, select register and frame register stay in mux4_scan_ctrl.

Test Plan:
1. All enabled: DWELL=4, ch_en=4'b1111; bench mux with a=1, b=0, c=1, d=1; pulse start at cycle 0. Required:
   - {s,s0} steps 00,01,10,11 over cycles 1-4, 5-8, 9-12, 13-16.
   - frame_valid=1 at cycle 17 with frame=4'b1101.
   - Handshake with frame_ready=1 and cont=0 → IDLE, busy=0.
2. Sparse mask: ch_en=4'b1010, DWELL=4, b=1, d=0. Required:
   - {s,s0} is 01 for cycles 1-4, then 11 for cycles 5-8.
   - frame_valid at cycle 9 with frame=4'b0010.
3. Empty mask and backpressure:
   - ch_en=0 → frame_valid at cycle 1 with frame=0.
   - Then, from scenario 1, hold frame_ready=0 for 10 cycles: frame=4'b1101 and {s,s0}=11 stay stable, and a start pulse is ignored.
4. Continuous mode: cont=1, frame_ready=1 at DONE, ch_en changed to 4'b0001 before the handshake. Required: the next scan selects channel 0 only, and frame_valid rises 1+4 cycles later.
5. Reset mid-scan: assert rst_n=0 during cycle 6 of scenario 1. Required:
   - s=s0=0, frame=0, frame_valid=0, busy=0 immediately, without waiting for a clock edge.
   - After release, a fresh start reproduces scenario 1 timing.
6. DWELL=1, all enabled, with a mux_y pattern that changes each cycle. Required: the select changes every cycle and frame_valid appears at cycle 5 with the matching bits.
